// File: rtl/alu_exec_unit_if.sv
// Bus bundle for the execute-stage ALU/PC-adder block: operands in, registered results out.
// There is no handshake: every rising clk edge out of reset samples the inputs and updates the results.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] imm32;

  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_res;
  logic             zero;
  logic             ovf;
  logic             cout;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_target;

  modport master (
    output alu_op, a, b, cin, pc, imm32,
    input  alu_ctl, alu_res, zero, ovf, cout, pc_plus4, branch_target
  );

  modport slave (
    input  alu_op, a, b, cin, pc, imm32,
    output alu_ctl, alu_res, zero, ovf, cout, pc_plus4, branch_target
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, MIPS ALU with flags, and PC+4 / branch-target adders.
// Everything is computed combinationally and registered once, giving a fixed one-cycle latency.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLTU = 4'b1000;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam int         MSB      = WIDTH - 1;

  logic [3:0]       alu_ctl_d, alu_ctl_q;
  logic [WIDTH-1:0] alu_res_d, alu_res_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;
  logic             cout_d, cout_q;
  logic [WIDTH-1:0] pc_plus4_d, pc_plus4_q;
  logic [WIDTH-1:0] branch_target_d, branch_target_q;

  logic [WIDTH-1:0] b_op;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] offset;

  always_comb begin
    alu_ctl_d = CTL_ADD;
    case (bus.alu_op)
      6'h20, 6'h21: alu_ctl_d = CTL_ADD;
      6'h22, 6'h23: alu_ctl_d = CTL_SUB;
      6'h24:        alu_ctl_d = CTL_AND;
      6'h25:        alu_ctl_d = CTL_OR;
      6'h26:        alu_ctl_d = CTL_XOR;
      6'h27:        alu_ctl_d = CTL_NOR;
      6'h2A:        alu_ctl_d = CTL_SLT;
      6'h2B:        alu_ctl_d = CTL_SLTU;
      default:      alu_ctl_d = CTL_ADD;
    endcase
  end

  // One shared adder: SUB is a + ~b + 1, so the overflow test below covers both ADD and SUB.
  always_comb begin
    b_op      = (alu_ctl_d == CTL_SUB) ? ~bus.b : bus.b;
    carry_in  = (alu_ctl_d == CTL_SUB) ? 1'b1 : bus.cin;
    sum       = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};
    alu_res_d = '0;
    ovf_d     = 1'b0;
    cout_d    = 1'b0;
    case (alu_ctl_d)
      CTL_AND:  alu_res_d = bus.a & bus.b;
      CTL_OR:   alu_res_d = bus.a | bus.b;
      CTL_XOR:  alu_res_d = bus.a ^ bus.b;
      CTL_NOR:  alu_res_d = ~(bus.a | bus.b);
      CTL_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      CTL_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: begin
        alu_res_d = sum[WIDTH-1:0];
        cout_d    = sum[WIDTH];
        ovf_d     = (bus.a[MSB] == b_op[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
    endcase
    zero_d = (alu_res_d == '0);
  end

  always_comb begin
    offset          = bus.imm32 << 2;
    pc_plus4_d      = bus.pc + WIDTH'(4);
    branch_target_d = pc_plus4_d + offset;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_ctl_q       <= '0;
      alu_res_q       <= '0;
      zero_q          <= 1'b0;
      ovf_q           <= 1'b0;
      cout_q          <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
    end else begin
      alu_ctl_q       <= alu_ctl_d;
      alu_res_q       <= alu_res_d;
      zero_q          <= zero_d;
      ovf_q           <= ovf_d;
      cout_q          <= cout_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign bus.alu_ctl       = alu_ctl_q;
  assign bus.alu_res       = alu_res_q;
  assign bus.zero          = zero_q;
  assign bus.ovf           = ovf_q;
  assign bus.cout          = cout_q;
  assign bus.pc_plus4      = pc_plus4_q;
  assign bus.branch_target = branch_target_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases then randomized traffic with mid-stream resets,
// each registered result compared against an arithmetic reference model through an expected queue.
module tb_alu_exec_unit;
  localparam int EXP_W = 4 + 32 + 3 + 32 + 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [EXP_W-1:0] exp_q[$];

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic signed_out_of_range(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  // Reference model: results from the operation definitions using 64-bit arithmetic.
  function automatic logic [EXP_W-1:0] model(input logic rst_n, input logic [5:0] op,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic cin, input logic [31:0] pc,
                                             input logic [31:0] imm);
    logic [3:0]  ctl;
    logic [31:0] res, p4, bt;
    logic        z, o, c;
    longint      sa, sb, sr;
    longint unsigned ua, ub, ur;
    if (!rst_n) return '0;
    case (op)
      6'h22, 6'h23: ctl = 4'b0110;
      6'h24:        ctl = 4'b0000;
      6'h25:        ctl = 4'b0001;
      6'h26:        ctl = 4'b0011;
      6'h27:        ctl = 4'b1100;
      6'h2A:        ctl = 4'b0111;
      6'h2B:        ctl = 4'b1000;
      default:      ctl = 4'b0010;
    endcase
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o = 1'b0;
    c = 1'b0;
    case (ctl)
      4'b0110: begin
        res = 32'(ua - ub);
        c   = (ua >= ub);
        sr  = sa - sb;
        o   = signed_out_of_range(sr);
      end
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0011: res = a ^ b;
      4'b1100: res = ~(a | b);
      4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: res = (ua < ub) ? 32'd1 : 32'd0;
      default: begin
        ur  = ua + ub + longint'(cin);
        res = ur[31:0];
        c   = ur[32];
        sr  = sa + sb + longint'(cin);
        o   = signed_out_of_range(sr);
      end
    endcase
    z  = (res == 32'd0);
    ur = {32'd0, pc} + 64'd4;
    p4 = ur[31:0];
    ur = ur + {32'd0, imm} * 64'd4;
    bt = ur[31:0];
    return {ctl, res, z, o, c, p4, bt};
  endfunction

  // driver: apply one set of inputs, scoreboard the expected outputs one edge later
  task automatic step(input logic rst_n, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic cin, input logic [31:0] pc,
                      input logic [31:0] imm);
    logic [EXP_W-1:0] e;
    @(negedge clk);
    reset      = rst_n;
    bus.alu_op = op;
    bus.a      = a;
    bus.b      = b;
    bus.cin    = cin;
    bus.pc     = pc;
    bus.imm32  = imm;
    exp_q.push_back(model(rst_n, op, a, b, cin, pc, imm));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("alu_ctl",       {28'd0, bus.alu_ctl}, {28'd0, e[102:99]});
    check_eq("alu_res",       bus.alu_res,          e[98:67]);
    check_eq("zero",          {31'd0, bus.zero},    {31'd0, e[66]});
    check_eq("ovf",           {31'd0, bus.ovf},     {31'd0, e[65]});
    check_eq("cout",          {31'd0, bus.cout},    {31'd0, e[64]});
    check_eq("pc_plus4",      bus.pc_plus4,         e[63:32]);
    check_eq("branch_target", bus.branch_target,    e[31:0]);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] ops [10];
    logic [5:0] op;
    logic [31:0] ra;
    checks = 0;
    errors = 0;
    ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    reset = 1'b0;
    bus.alu_op = 6'h20;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.pc = '0;
    bus.imm32 = '0;

    // reset held two edges with nonzero inputs, then release loads the inputs
    step(1'b0, 6'h20, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0040_0000, 32'h10);
    step(1'b0, 6'h22, 32'h5, 32'h5, 1'b0, 32'h0040_0010, 32'h3);
    step(1'b1, 6'h20, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0040_0000, 32'h10);

    step(1'b1, 6'h20, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h20, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h22, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h22, 32'h8000_0000, 32'h1, 1'b1, 32'h0, 32'h0);
    step(1'b1, 6'h2A, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h2B, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0, 32'h0);
    step(1'b1, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0, 32'h0);
    step(1'b1, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0, 32'h0);
    step(1'b1, 6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0, 32'h0);
    step(1'b1, 6'h27, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0, 32'h0);
    step(1'b1, 6'h3F, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'h0, 32'h0);
    step(1'b1, 6'h20, 32'h1, 32'h2, 1'b0, 32'h0040_0000, 32'hFFFF_FFFF);
    step(1'b1, 6'h20, 32'h1, 32'h2, 1'b0, 32'hFFFF_FFFC, 32'h1);
    // mid-stream reset, then normal load on the following edge
    step(1'b0, 6'h22, 32'h9, 32'h3, 1'b0, 32'h100, 32'h7);
    step(1'b1, 6'h22, 32'h9, 32'h3, 1'b0, 32'h100, 32'h7);

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 9)];
      ra = rand_operand();
      step(($urandom_range(0, 24) != 0), op, ra,
           ($urandom_range(0, 9) == 0) ? ra : rand_operand(),
           1'($urandom_range(0, 1)), $urandom, rand_operand());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
